alu_pipe_mdu: RTL and testbench

ALU_PIPE_MDU -- requirements
Module: alu_pipe_mdu

---
 rtl/alu_pipe_mdu.sv | 191 +++++++++++++++++++
 tb/tb_alu_pipe_mdu.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe_mdu.sv
// Pipelined ALU with a single-cycle datapath and an iterative shift-add unsigned multiplier.
// One output register holds each result until the consumer takes it.
module alu_pipe_mdu #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       ctl,
   input  logic [WIDTH-1:0] dataA,
   input  logic [WIDTH-1:0] dataB,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] dataOut,
   output logic [WIDTH-1:0] dataHi,
   output logic             zero,
   output logic             ovf,
   output logic             err
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_SLT   = 4'b0111;
   localparam logic [3:0] OP_SLTU  = 4'b1000;
   localparam logic [3:0] OP_NOR   = 4'b1100;
   localparam logic [3:0] OP_SLL   = 4'b1010;
   localparam logic [3:0] OP_SRL   = 4'b1011;
   localparam logic [3:0] OP_SRA   = 4'b1001;
   localparam logic [3:0] OP_MULTU = 4'b1101;

   typedef enum logic {IDLE, MUL} state_t;

   state_t           r_state;
   state_t           w_nextState;
   logic             w_accept;
   logic             w_mulStart;
   logic             w_mulLoad;

   logic [CW-1:0]    r_count;
   logic             r_mulDone;
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mulHi;
   logic [WIDTH-1:0] r_mulLo;
   logic [WIDTH:0]   w_mulSum;

   logic             r_outValid;
   logic [WIDTH-1:0] r_dataOut;
   logic [WIDTH-1:0] r_dataHi;
   logic             r_zero;
   logic             r_ovf;
   logic             r_err;

   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] w_diff;
   logic [SHW-1:0]   w_shamt;
   logic [WIDTH-1:0] w_result;
   logic             w_ovf;
   logic             w_err;

   assign w_sum   = dataA + dataB;
   assign w_diff  = dataA - dataB;
   assign w_shamt = dataB[SHW-1:0];

   always_comb begin
      w_result = '0;
      w_ovf    = 1'b0;
      w_err    = 1'b0;
      case (ctl)
         OP_AND:  w_result = dataA & dataB;
         OP_OR:   w_result = dataA | dataB;
         OP_NOR:  w_result = ~(dataA | dataB);
         OP_ADD: begin
            w_result = w_sum;
            w_ovf    = (dataA[WIDTH-1] == dataB[WIDTH-1]) && (w_sum[WIDTH-1] != dataA[WIDTH-1]);
         end
         OP_SUB: begin
            w_result = w_diff;
            w_ovf    = (dataA[WIDTH-1] != dataB[WIDTH-1]) && (w_diff[WIDTH-1] != dataA[WIDTH-1]);
         end
         OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, ($signed(dataA) < $signed(dataB))};
         OP_SLTU: w_result = {{(WIDTH-1){1'b0}}, (dataA < dataB)};
         OP_SLL:  w_result = dataA << w_shamt;
         OP_SRL:  w_result = dataA >> w_shamt;
         OP_SRA:  w_result = $signed(dataA) >>> w_shamt;
         OP_MULTU: w_result = '0;
         default: w_err = 1'b1;
      endcase
   end

   // Handshake decode; flush suppresses any accept on the same edge
   always_comb begin
      in_ready   = reset_n && (r_state == IDLE) && (!r_outValid || out_ready);
      w_accept   = in_valid && in_ready && !flush;
      w_mulStart = w_accept && (ctl == OP_MULTU);
      w_mulLoad  = (r_state == MUL) && r_mulDone && !r_outValid && !flush;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: if (w_mulStart) w_nextState = MUL;
         MUL:  if (flush || w_mulLoad) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   assign w_mulSum = {1'b0, r_mulHi} + (r_mulLo[0] ? {1'b0, r_mcand} : '0);

   // Product lives in {r_mulHi, r_mulLo}; the multiplier drains out of r_mulLo one bit per cycle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count   <= '0;
         r_mulDone <= 1'b0;
         r_mcand   <= '0;
         r_mulHi   <= '0;
         r_mulLo   <= '0;
      end else if (flush) begin
         r_count   <= '0;
         r_mulDone <= 1'b0;
      end else if (w_mulStart) begin
         r_count   <= '0;
         r_mulDone <= 1'b0;
         r_mcand   <= dataA;
         r_mulHi   <= '0;
         r_mulLo   <= dataB;
      end else if ((r_state == MUL) && !r_mulDone) begin
         r_mulHi <= w_mulSum[WIDTH:1];
         r_mulLo <= {w_mulSum[0], r_mulLo[WIDTH-1:1]};
         if (r_count == LAST) r_mulDone <= 1'b1;
         else                 r_count   <= r_count + 1'b1;
      end else if (w_mulLoad) begin
         r_count   <= '0;
         r_mulDone <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_outValid <= 1'b0;
         r_dataOut  <= '0;
         r_dataHi   <= '0;
         r_zero     <= 1'b0;
         r_ovf      <= 1'b0;
         r_err      <= 1'b0;
      end else if (flush) begin
         r_outValid <= 1'b0;
         r_dataOut  <= '0;
         r_dataHi   <= '0;
         r_zero     <= 1'b0;
         r_ovf      <= 1'b0;
         r_err      <= 1'b0;
      end else if (w_accept && (ctl != OP_MULTU)) begin
         r_outValid <= 1'b1;
         r_dataOut  <= w_result;
         r_dataHi   <= '0;
         r_zero     <= (w_result == '0);
         r_ovf      <= w_ovf;
         r_err      <= w_err;
      end else if (w_mulLoad) begin
         r_outValid <= 1'b1;
         r_dataOut  <= r_mulLo;
         r_dataHi   <= r_mulHi;
         r_zero     <= (r_mulLo == '0);
         r_ovf      <= 1'b0;
         r_err      <= 1'b0;
      end else if (r_outValid && out_ready) begin
         r_outValid <= 1'b0;
      end
   end

   assign out_valid = r_outValid;
   assign dataOut   = r_dataOut;
   assign dataHi    = r_dataHi;
   assign zero      = r_zero;
   assign ovf       = r_ovf;
   assign err       = r_err;

endmodule

// File: tb/tb_alu_pipe_mdu.sv
// Directed testbench for alu_pipe_mdu (WIDTH=32) with hand-computed expected values.
module tb_alu_pipe_mdu;

   logic        clk;
   logic        reset_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  ctl;
   logic [31:0] dataA;
   logic [31:0] dataB;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] dataOut;
   logic [31:0] dataHi;
   logic        zero;
   logic        ovf;
   logic        err;

   int vectors;
   int miscompares;
   int lat;
   logic sawValid;

   alu_pipe_mdu #(.WIDTH(32)) dut (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .ctl(ctl),
      .dataA(dataA), .dataB(dataB),
      .out_valid(out_valid), .out_ready(out_ready),
      .dataOut(dataOut), .dataHi(dataHi),
      .zero(zero), .ovf(ovf), .err(err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Present one operation and step to just after the accepting edge
   task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      ctl      = op;
      dataA    = a;
      dataB    = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic checkSingle(input string tag, input logic [31:0] expOut, input logic [3:0] expFlags);
      checkOutput({tag, "_out"}, {32'h0, dataOut}, {32'h0, expOut});
      checkOutput({tag, "_hi"}, {32'h0, dataHi}, 64'h0);
      checkOutput({tag, "_flags"}, {60'h0, out_valid, zero, ovf, err}, {60'h0, expFlags});
   endtask

   task automatic waitResult(input string tag);
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checkOutput({tag, "_latency"}, 64'(lat), 64'd33);
   endtask

   task automatic watchNoValid(input string tag);
      sawValid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         sawValid = sawValid | out_valid;
      end
      checkOutput(tag, {63'h0, sawValid}, 64'h0);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset_n     = 1'b0;
      flush       = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b1;
      ctl         = 4'b0000;
      dataA       = '0;
      dataB       = '0;

      #1;
      checkOutput("reset_ctl", {62'h0, out_valid, in_ready}, 64'h0);
      checkOutput("reset_data", {dataHi, dataOut}, 64'h0);
      checkOutput("reset_flags", {61'h0, zero, ovf, err}, 64'h0);

      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("ready_after_reset", {63'h0, in_ready}, 64'h1);

      applyStimulus(4'b0010, 32'h7FFFFFFF, 32'h00000001);
      checkSingle("add_ovf", 32'h80000000, 4'b1010);

      applyStimulus(4'b0110, 32'd5, 32'd5);
      checkSingle("sub_zero", 32'h0, 4'b1100);
      applyStimulus(4'b0111, 32'hFFFFFFFF, 32'd1);
      checkSingle("slt", 32'h1, 4'b1000);
      applyStimulus(4'b1000, 32'hFFFFFFFF, 32'd1);
      checkSingle("sltu", 32'h0, 4'b1100);
      applyStimulus(4'b1001, 32'h80000000, 32'h00000024);
      checkSingle("sra", 32'hF8000000, 4'b1000);
      applyStimulus(4'b1010, 32'h00000001, 32'd31);
      checkSingle("sll", 32'h80000000, 4'b1000);
      applyStimulus(4'b1011, 32'h80000000, 32'hFFFFFFE4);
      checkSingle("srl", 32'h08000000, 4'b1000);
      applyStimulus(4'b1100, 32'h0F0F0000, 32'h00F000F0);
      checkSingle("nor", 32'hF000FF0F, 4'b1000);
      applyStimulus(4'b0001, 32'h12000034, 32'h00560000);
      checkSingle("or", 32'h12560034, 4'b1000);
      applyStimulus(4'b0110, 32'h80000000, 32'd1);
      checkSingle("sub_ovf", 32'h7FFFFFFF, 4'b1010);
      applyStimulus(4'b0010, 32'hFFFFFFFF, 32'd1);
      checkSingle("add_wrap", 32'h0, 4'b1100);
      applyStimulus(4'b0011, 32'h1234, 32'h5678);
      checkSingle("illegal", 32'h0, 4'b1101);
      checkOutput("b2b_ready", {63'h0, in_ready}, 64'h1);

      applyStimulus(4'b1101, 32'hFFFFFFFF, 32'hFFFFFFFF);
      in_valid = 1'b0;
      checkOutput("mul_accept", {62'h0, out_valid, in_ready}, 64'h0);
      for (int k = 1; k <= 32; k++) begin
         @(posedge clk);
         #1;
         checkOutput("mul_busy", {62'h0, out_valid, in_ready}, 64'h0);
      end
      @(posedge clk);
      #1;
      checkOutput("mul_max_prod", {dataHi, dataOut}, 64'hFFFFFFFE_00000001);
      checkOutput("mul_max_flags", {60'h0, out_valid, zero, ovf, err}, 64'h8);

      applyStimulus(4'b1101, 32'd3, 32'd5);
      in_valid = 1'b0;
      waitResult("mul_small");
      checkOutput("mul_small_prod", {dataHi, dataOut}, 64'd15);

      applyStimulus(4'b1101, 32'h80000000, 32'd4);
      in_valid = 1'b0;
      waitResult("mul_hi");
      checkOutput("mul_hi_prod", {dataHi, dataOut}, 64'h00000002_00000000);
      checkOutput("mul_hi_flags", {60'h0, out_valid, zero, ovf, err}, 64'hC);

      @(posedge clk);
      #1;
      applyStimulus(4'b0000, 32'hF0F0F0F0, 32'hFF00FF00);
      out_ready = 1'b0;
      ctl       = 4'b0010;
      dataA     = 32'd1;
      dataB     = 32'd1;
      in_valid  = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         checkOutput("hold_data", {32'h0, dataOut}, 64'hF000F000);
         checkOutput("hold_ctl", {62'h0, out_valid, in_ready}, 64'h2);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checkSingle("release_add", 32'h2, 4'b1000);

      flush = 1'b1;
      applyStimulus(4'b0010, 32'd7, 32'd7);
      flush    = 1'b0;
      in_valid = 1'b0;
      checkOutput("flush_idle", {63'h0, out_valid}, 64'h0);

      applyStimulus(4'b1101, 32'd3, 32'd5);
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      checkOutput("flush_mul_ready", {62'h0, out_valid, in_ready}, 64'h1);
      watchNoValid("flush_mul_novalid");
      applyStimulus(4'b0010, 32'd2, 32'd3);
      in_valid = 1'b0;
      checkSingle("add_after_flush", 32'd5, 4'b1000);

      applyStimulus(4'b1101, 32'd3, 32'd5);
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      checkOutput("async_reset_ctl", {62'h0, out_valid, in_ready}, 64'h0);
      checkOutput("async_reset_data", {dataHi, dataOut}, 64'h0);
      @(negedge clk);
      reset_n = 1'b1;
      watchNoValid("reset_mul_novalid");
      checkOutput("reset_mul_ready", {63'h0, in_ready}, 64'h1);
      applyStimulus(4'b0010, 32'd2, 32'd3);
      in_valid = 1'b0;
      checkSingle("add_after_reset", 32'd5, 4'b1000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
